// File: rtl/fpga_board_reset_seq_pkg.sv
// Shared types and board defaults for the board-level reset/power-up sequencer.
package fpga_board_reset_seq_pkg;

    // Sequencer states; encodings are also shown on the debug LEDs.
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SD_PWR    = 3'd1,
        SOC_HOLD  = 3'd2,
        RUN       = 3'd3
    } seq_state_e;

    // Nexys board defaults, 100 MHz reference clock.
    localparam int unsigned NEXYS_DEBOUNCE_CYCLES = 50000;   // 0.5 ms button settle
    localparam int unsigned NEXYS_SD_PWR_CYCLES   = 100000;  // 1 ms SD supply ramp
    localparam int unsigned NEXYS_SOC_RST_CYCLES  = 256;     // SoC reset hold
    localparam int unsigned NEXYS_CNT_W           = 20;

    // Registered pin-level outputs, all active-low except ready.
    typedef struct packed {
        logic soc_rst_n;
        logic jtag_trst_n;
        logic sd_pwr_en_n;
        logic ready;
    } seq_out_t;

    // Output pattern owned by each state; loaded together with the state register.
    function automatic seq_out_t state_outputs(seq_state_e s);
        seq_out_t o;
        o.soc_rst_n   = 1'b0;
        o.jtag_trst_n = 1'b0;
        o.sd_pwr_en_n = 1'b0;
        o.ready       = 1'b0;
        case (s)
            WAIT_LOCK: o.sd_pwr_en_n = 1'b1;
            RUN: begin
                o.soc_rst_n   = 1'b1;
                o.jtag_trst_n = 1'b1;
                o.ready       = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // A delay must be non-zero and reachable by a counter of the given width.
    function automatic bit cycles_ok(int unsigned cycles, int unsigned width);
        return (cycles != 0) && (longint'(cycles) < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/fpga_board_reset_seq_debounce.sv
// Two-flop synchronizer followed by a level debouncer for a bouncy async input.
import fpga_board_reset_seq_pkg::*;

module rst_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = NEXYS_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = NEXYS_CNT_W,
    parameter logic        RESET_VAL       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (!cycles_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_debounce
        $error("rst_debounce: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw pin into the clock domain; reset to the idle level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= RESET_VAL;
            sync_q2 <= RESET_VAL;
        end else begin
            sync_q1 <= din_i;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            dout_o <= RESET_VAL;
        end else if (sync_q2 == dout_o) begin
            cnt_q  <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            dout_o <= sync_q2;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/fpga_board_reset_seq.sv
// Board reset sequencer: clock lock -> SD power -> SoC/JTAG reset release.
// Lock loss is a cold restart (SD power cycled); the button is a warm restart.
import fpga_board_reset_seq_pkg::*;

module fpga_board_reset_seq #(
    parameter int unsigned DEBOUNCE_CYCLES = NEXYS_DEBOUNCE_CYCLES,
    parameter int unsigned SD_PWR_CYCLES   = NEXYS_SD_PWR_CYCLES,
    parameter int unsigned SOC_RST_CYCLES  = NEXYS_SOC_RST_CYCLES,
    parameter int unsigned CNT_W           = NEXYS_CNT_W
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clk_locked_i,
    input  logic       btn_reset_ni,
    output logic       soc_rst_no,
    output logic       jtag_trst_no,
    output logic       sd_pwr_en_no,
    output logic       ready_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] SD_LAST  = CNT_W'(SD_PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOC_LAST = CNT_W'(SOC_RST_CYCLES - 1);

    if (!cycles_ok(SD_PWR_CYCLES, CNT_W)) begin : g_bad_sd
        $error("fpga_board_reset_seq: SD_PWR_CYCLES must be in 1 .. 2**CNT_W-1");
    end
    if (!cycles_ok(SOC_RST_CYCLES, CNT_W)) begin : g_bad_soc
        $error("fpga_board_reset_seq: SOC_RST_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    logic             lock_q1;
    logic             lock_q2;
    logic             btn_db;     // debounced button, 1 = released
    logic             btn_pressed;
    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    seq_out_t         out_q;

    // Lock is a clean level from the clock generator, so a plain synchronizer suffices.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q1 <= 1'b0;
            lock_q2 <= 1'b0;
        end else begin
            lock_q1 <= clk_locked_i;
            lock_q2 <= lock_q1;
        end
    end

    rst_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (1'b1)
    ) u_btn_db (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (btn_reset_ni),
        .dout_o (btn_db)
    );

    assign btn_pressed = ~btn_db;

    // Sequencer FSM; outputs are loaded with the next state so pins follow the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            out_q   <= state_outputs(WAIT_LOCK);
        end else if (state_q != WAIT_LOCK && !lock_q2) begin
            // Lock loss wins over the button and over counter expiry.
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            out_q   <= state_outputs(WAIT_LOCK);
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (lock_q2) begin
                        state_q <= SD_PWR;
                        out_q   <= state_outputs(SD_PWR);
                    end
                end
                SD_PWR: begin
                    if (cnt_q == SD_LAST) begin
                        state_q <= SOC_HOLD;
                        cnt_q   <= '0;
                        out_q   <= state_outputs(SOC_HOLD);
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                SOC_HOLD: begin
                    // A held button stalls the release; the hold time restarts on release.
                    if (btn_pressed) begin
                        cnt_q   <= '0;
                    end else if (cnt_q == SOC_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        out_q   <= state_outputs(RUN);
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= '0;
                    if (btn_pressed) begin
                        state_q <= SOC_HOLD;
                        out_q   <= state_outputs(SOC_HOLD);
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                    cnt_q   <= '0;
                    out_q   <= state_outputs(WAIT_LOCK);
                end
            endcase
        end
    end

    assign soc_rst_no   = out_q.soc_rst_n;
    assign jtag_trst_no = out_q.jtag_trst_n;
    assign sd_pwr_en_no = out_q.sd_pwr_en_n;
    assign ready_o      = out_q.ready;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fpga_board_reset_seq.sv
// Scoreboard bench for the board reset sequencer: directed test-plan scenarios
// followed by random button bounce, lock drops and reset pulses.
module tb_fpga_board_reset_seq;

    localparam int DB   = 4;
    localparam int SDC  = 8;
    localparam int SRC  = 5;
    localparam int CW   = 8;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       btn = 1'b1;
    logic       soc_rst_n, jtag_trst_n, sd_pwr_en_n, ready;
    logic [2:0] state;

    fpga_board_reset_seq #(
        .DEBOUNCE_CYCLES (DB),
        .SD_PWR_CYCLES   (SDC),
        .SOC_RST_CYCLES  (SRC),
        .CNT_W           (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clk_locked_i (lock),
        .btn_reset_ni (btn),
        .soc_rst_no   (soc_rst_n),
        .jtag_trst_no (jtag_trst_n),
        .sd_pwr_en_no (sd_pwr_en_n),
        .ready_o      (ready),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [2:0] st;
        logic       soc, trst, sd, rdy;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Pin history per clock edge; the reference model works on these histories.
    bit lock_p[MAXE];
    bit btn_p[MAXE];
    bit rst_p[MAXE];
    bit acc_r[MAXE];   // accepted (debounced) button level after each edge, 1 = released
    int k = 0;
    int m_state = 0;   // 0 wait lock, 1 SD power ramp, 2 SoC hold, 3 run
    int m_entry = 0;
    int m_last  = 0;   // last edge that restarted the SoC hold time

    // Level the logic sees at edge e: the pin two edges earlier, unless a reset intervened.
    function automatic bit seen_lock(int e);
        if (e < 2 || rst_p[e-1] || rst_p[e-2]) return 1'b0;
        return lock_p[e-2];
    endfunction

    function automatic bit seen_btn(int e);
        if (e < 2 || rst_p[e-1] || rst_p[e-2]) return 1'b1;
        return btn_p[e-2];
    endfunction

    function automatic void model_step(int e);
        bit pa, sl, flip, pressed;
        pa = (e == 0) ? 1'b1 : acc_r[e-1];
        if (rst_p[e]) begin
            acc_r[e] = 1'b1;
            m_state  = 0;
            return;
        end
        // New level accepted once the seen level has disagreed for DB edges in a row.
        flip = (e >= DB - 1);
        if (flip)
            for (int j = e - DB + 1; j <= e; j++)
                if (rst_p[j] || seen_btn(j) == pa) flip = 1'b0;
        acc_r[e] = flip ? ~pa : pa;
        sl      = seen_lock(e);
        pressed = ~pa;
        if (m_state != 0 && !sl) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (sl) begin m_state = 1; m_entry = e; end
                1: if (e - m_entry == SDC) begin m_state = 2; m_last = e; end
                2: begin
                    if (pressed) m_last = e;
                    else if (e - m_last == SRC) m_state = 3;
                end
                default: if (pressed) begin m_state = 2; m_last = e; end
            endcase
        end
    endfunction

    // One clock edge: log pins, advance the model, queue the expected outputs.
    task automatic tick();
        exp_t x;
        if (k >= MAXE) begin
            $display("FAIL edge_budget got=%0d limit=%0d", k, MAXE);
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "edge budget exhausted");
        end
        lock_p[k] = lock;
        btn_p[k]  = btn;
        rst_p[k]  = rst;
        model_step(k);
        x.k    = k;
        x.st   = 3'(m_state);
        x.sd   = (m_state == 0);
        x.soc  = (m_state == 3);
        x.trst = (m_state == 3);
        x.rdy  = (m_state == 3);
        @(posedge clk);
        #1;
        sb_q.push_back(x);
        k++;
    endtask

    // Monitor: compare every presented cycle and note edges where key pins switch.
    exp_t mx;
    logic prev_sd = 1'b1, prev_soc = 1'b0;
    int   sd_fall_k = -1, sd_rise_k = -1, soc_rise_k = -1, soc_fall_k = -1;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mx = sb_q.pop_front();
            checks++;
            if ({state, soc_rst_n, jtag_trst_n, sd_pwr_en_n, ready} !==
                {mx.st, mx.soc, mx.trst, mx.sd, mx.rdy}) begin
                failures++;
                $display("FAIL cycle_outputs edge=%0d got st=%0d soc=%b trst=%b sd=%b rdy=%b want st=%0d soc=%b trst=%b sd=%b rdy=%b",
                         mx.k, state, soc_rst_n, jtag_trst_n, sd_pwr_en_n, ready,
                         mx.st, mx.soc, mx.trst, mx.sd, mx.rdy);
            end
            if (prev_sd === 1'b1 && sd_pwr_en_n === 1'b0) sd_fall_k = mx.k;
            if (prev_sd === 1'b0 && sd_pwr_en_n === 1'b1) sd_rise_k = mx.k;
            if (prev_soc === 1'b0 && soc_rst_n === 1'b1) soc_rise_k = mx.k;
            if (prev_soc === 1'b1 && soc_rst_n === 1'b0) soc_fall_k = mx.k;
            prev_sd  = sd_pwr_en_n;
            prev_soc = soc_rst_n;
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    int L, P, R, D, Q, r, n;

    initial begin
        // Power-on reset, then cold boot with lock arriving around cycle 10.
        repeat (3) tick();
        rst = 1'b0;
        repeat (7) tick();
        lock = 1'b1; L = k;
        repeat (20) tick();
        check_int("cold_sd_on", sd_fall_k, L + 2);
        check_int("cold_soc_release", soc_rise_k, L + 2 + SDC + SRC);

        // Short bounces while running must not restart anything.
        repeat (5) begin
            btn = 1'b0; repeat (DB - 1) tick();
            btn = 1'b1; tick();
        end
        repeat (6) tick();
        check_int("bounce_no_reset", soc_fall_k, -1);

        // Warm reset: long press, then release.
        btn = 1'b0; P = k;
        repeat (20) tick();
        btn = 1'b1; R = k;
        repeat (15) tick();
        check_int("warm_soc_assert", soc_fall_k, P + 2 + DB);
        check_int("warm_soc_release", soc_rise_k, R + 2 + DB + SRC - 1);
        check_int("warm_sd_kept_on", sd_rise_k, -1);

        // Lock loss while in SOC_HOLD with the button pressed.
        btn = 1'b0;
        repeat (DB + 4) tick();
        lock = 1'b0; D = k;
        repeat (5) tick();
        check_int("lockloss_sd_off", sd_rise_k, D + 2);
        lock = 1'b1; btn = 1'b1; L = k;
        repeat (25) tick();
        check_int("relock_sd_on", sd_fall_k, L + 2);
        check_int("relock_soc_release", soc_rise_k, L + 2 + SDC + SRC);

        // Reset pulse in the middle of the SD power ramp (counter at 5).
        lock = 1'b0;
        repeat (5) tick();
        lock = 1'b1; L = k;
        repeat (8) tick();
        rst = 1'b1; tick();
        rst = 1'b0; Q = k;
        repeat (25) tick();
        check_int("midrst_sd_off", sd_rise_k, L + 8);
        check_int("midrst_sd_on", sd_fall_k, Q + 2);
        check_int("midrst_soc_release", soc_rise_k, Q + 2 + SDC + SRC);

        // Button held from power-up: sequence stalls in SOC_HOLD.
        rst = 1'b1; btn = 1'b0; lock = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (7) tick();
        lock = 1'b1; L = k;
        repeat (30) tick();
        R = k;
        check_int("held_stall_no_release", (soc_rise_k < L) ? 1 : 0, 1);
        check_int("held_sd_on", sd_fall_k, L + 2);
        btn = 1'b1;
        repeat (15) tick();
        check_int("held_release_run", soc_rise_k, R + 2 + DB + SRC - 1);

        // Random bounce, lock drops and reset pulses against the reference model.
        while (k < 1800) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst = 1'b1; repeat ($urandom_range(1, 2)) tick(); rst = 1'b0;
            end else if (r < 10) begin
                lock = 1'b0; repeat ($urandom_range(1, 6)) tick(); lock = 1'b1;
            end else if (r < 45) begin
                btn = 1'b0; repeat ($urandom_range(1, 12)) tick(); btn = 1'b1;
            end else begin
                n = $urandom_range(1, 20);
                repeat (n) tick();
            end
        end
        repeat (30) tick();

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
